nem_ohmux_seldrv: RTL and testbench
===================================

Name: nem_ohmux_seldrv

Overview:
- Sequential select driver and reader for the inverting NEM one-hot mux cells (nem_ohmux_invd0_*).
- Accepts a binary select request and drives the relay select lines S0..S(N-1) with break-before-make sequencing.
- Waits out relay mechanical settle time, then samples the mux ZN output and returns the un-inverted data bit on a valid/ready response channel.
- Sits between digital control logic and one NEM mux column.

Parameters:
- N_IN, 4, number of mux inputs / select lines (2..16).
- SELW, $clog2(N_IN), width of the binary select.
- OFF_CYC, 2, break (all-off) dwell in cycles, >=1.
- ON_CYC, 4, make/settle dwell in cycles, >=1.
- CNTW, 8, dwell counter width; OFF_CYC and ON_CYC must be < 2^CNTW.

Ports:
- CP, input, 1, clock, rising edge.
- RSTN, input, 1, reset: synchronous, active-low.
- REQ_VALID, input, 1, select request valid.
- REQ_READY, output, 1, request accepted when REQ_VALID & REQ_READY at a CP edge.
- REQ_SEL, input, SELW, binary index of the input to select.
- RSP_VALID, output, 1, response valid.
- RSP_READY, input, 1, response consumed when RSP_VALID & RSP_READY.
- RSP_DATA, output, 1, ~ZN_0 sampled after settle.
- RSP_ERR, output, 1, REQ_SEL >= N_IN.
- S, output, N_IN, one-hot relay select (S[i] drives mux pin Si).
- ZN_0, input, 1, inverted mux output.

Behaviour:
- Reset: while RSTN=0 at a CP edge, the following clear at that edge: state=IDLE, S=0, active-flag=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, counter=0. REQ_READY=1 in the cycle after reset releases.
- Reset mid-operation aborts any dwell. S drops to 0 at the reset edge. No response is produced for the aborted request.
- States: IDLE, BREAK, MAKE, SAMPLE, RESP.
- REQ_READY=1 only in IDLE.
- Accept at edge t, normal path: BREAK in cycles t+1..t+OFF_CYC with S=0 → MAKE for ON_CYC cycles with S=onehot(REQ_SEL) → SAMPLE for 1 cycle → RESP.
- Normal-path latency: RSP_VALID rises at t+OFF_CYC+ON_CYC+2.
- Fast path: at accept, if active-flag=1 and REQ_SEL equals the latched select, go directly to SAMPLE. S is unchanged and glitch-free. RSP_VALID rises at t+2.
- SAMPLE: at the end of the cycle, RSP_DATA <= ~ZN_0 and RSP_ERR <= 0. Set active-flag=1 and latch the select.
- Error path: REQ_SEL >= N_IN (possible only when N_IN is not a power of 2). BREAK as normal, then go directly to RESP with S=0, RSP_ERR=1, RSP_DATA=0, active-flag=0. RSP_VALID rises at t+OFF_CYC+1.
- RESP: RSP_VALID=1 and RSP_DATA/RSP_ERR are held stable until RSP_READY. On the handshake edge, return to IDLE.
- S invariant: S is held in RESP and IDLE (relay stays closed after sample). S is never multi-hot in any cycle. Every transition between two different non-zero S values passes through at least OFF_CYC cycles of S=0.
- Counter: loaded with dwell-1 on state entry, decrements each cycle, and the state exits when the counter is 0. No wrap.
- REQ_SEL is captured at accept. Later changes to REQ_SEL are ignored.
- ZN_0 is sampled directly, with no synchronizer: the relay is static and the same domain after settle.

Decomposition:
- Package nem_relay_pkg holds:
  - state enum type;
  - onehot(sel) function returning N_IN bits, all zero when out of range;
  - default OFF_CYC and ON_CYC constants.
- One sub-module, nem_relay_dwell: loadable down-counter with load, load value, and zero flag; CNTW wide. The FSM and S/response registers stay in the top.

Test Plan:
- Reset: assert RSTN=0 mid-MAKE with S=0100 → at the next edge S=0000, RSP_VALID=0, state IDLE; REQ_READY=1 one cycle after RSTN=1.
- Normal select: N_IN=4, OFF=2, ON=4, accept REQ_SEL=2 at t, ZN_0 tied 0 → S=0000 at t+1..t+2, S=0100 at t+3..t+7, RSP_VALID=1 at t+8 with RSP_DATA=1, RSP_ERR=0.
- Switch: active sel=2, request sel=1 → S=0000 for exactly 2 cycles, then 0010; never 0110.
- Fast path: active sel=1, request sel=1 with ZN_0=1 → S stays 0010 every cycle, RSP_VALID at t+2, RSP_DATA=0.
- Backpressure: hold RSP_READY=0 for 5 cycles in RESP while toggling ZN_0 → RSP_DATA stable, REQ_READY=0; after RSP_READY=1, REQ_READY=1 the next cycle.
- Error: N_IN=3, request sel=3 → S=000 throughout, RSP_VALID at t+3 with RSP_ERR=1, RSP_DATA=0; a following sel=0 takes the full break/make path.

Source files
------------

// File: rtl/nem_relay_pkg.sv
// Shared types and helpers for the NEM relay select driver.
// Holds the FSM state type, default dwell constants and the one-hot decoder.
package nem_relay_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_MAKE,
        ST_SAMPLE,
        ST_RESP
    } state_t;

    localparam int MAX_N       = 16;
    localparam int DEF_OFF_CYC = 2;
    localparam int DEF_ON_CYC  = 4;

    // Out-of-range selects decode to all-zero, which the driver uses as its error flag.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned sel, input int unsigned n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if ((sel == i) && (i < n)) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nem_relay_dwell.sv
// Loadable down-counter that times relay break and make dwells.
// Holds at zero instead of wrapping; zero flags the last cycle of a dwell.
module nem_relay_dwell #(
    parameter int CNTW = 8
) (
    input  logic            CP,
    input  logic            RSTN,
    input  logic            load,
    input  logic [CNTW-1:0] load_val,
    output logic            zero
);

    logic [CNTW-1:0] cnt_reg;

    always_ff @(posedge CP) begin
        if (!RSTN) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/nem_ohmux_seldrv.sv
// Break-before-make select driver and reader for one inverting NEM one-hot mux column.
// Opens all relays, closes the requested one, waits for settle, then returns ~ZN_0.
module nem_ohmux_seldrv
    import nem_relay_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int SELW    = $clog2(N_IN),
    parameter int OFF_CYC = DEF_OFF_CYC,
    parameter int ON_CYC  = DEF_ON_CYC,
    parameter int CNTW    = 8
) (
    input  logic            CP,
    input  logic            RSTN,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [SELW-1:0] REQ_SEL,
    output logic            RSP_VALID,
    input  logic            RSP_READY,
    output logic            RSP_DATA,
    output logic            RSP_ERR,
    output logic [N_IN-1:0] S,
    input  logic            ZN_0
);

    state_t            state_reg;
    logic [N_IN-1:0]   s_reg;
    logic              active_reg;
    logic [SELW-1:0]   active_sel_reg;
    logic [SELW-1:0]   sel_reg;
    logic              req_ready_reg;
    logic              rsp_valid_reg;
    logic              rsp_data_reg;
    logic              rsp_err_reg;

    logic              accept;
    logic              fast;
    logic              sel_bad;
    logic [MAX_N-1:0]  oh_full;
    logic              dwell_load;
    logic [CNTW-1:0]   dwell_val;
    logic              dwell_zero;

    always_comb begin
        accept     = (state_reg == ST_IDLE) && REQ_VALID && req_ready_reg;
        fast       = active_reg && (REQ_SEL == active_sel_reg);
        oh_full    = onehot(32'(sel_reg), N_IN);
        sel_bad    = ~|oh_full;
        dwell_load = (accept && !fast) ||
                     ((state_reg == ST_BREAK) && dwell_zero && !sel_bad);
        dwell_val  = (state_reg == ST_IDLE) ? CNTW'(OFF_CYC - 1) : CNTW'(ON_CYC - 1);
    end

    nem_relay_dwell #(
        .CNTW (CNTW)
    ) u_dwell (
        .CP       (CP),
        .RSTN     (RSTN),
        .load     (dwell_load),
        .load_val (dwell_val),
        .zero     (dwell_zero)
    );

    always_ff @(posedge CP) begin
        if (!RSTN) begin
            state_reg      <= ST_IDLE;
            s_reg          <= '0;
            active_reg     <= 1'b0;
            active_sel_reg <= '0;
            sel_reg        <= '0;
            req_ready_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= 1'b0;
            rsp_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (accept) begin
                        sel_reg       <= REQ_SEL;
                        req_ready_reg <= 1'b0;
                        if (fast) begin
                            // Relay already closed on this input: skip straight to the read.
                            state_reg <= ST_SAMPLE;
                        end else begin
                            state_reg  <= ST_BREAK;
                            s_reg      <= '0;
                            active_reg <= 1'b0;
                        end
                    end
                end
                ST_BREAK: begin
                    if (dwell_zero) begin
                        if (sel_bad) begin
                            state_reg     <= ST_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_data_reg  <= 1'b0;
                        end else begin
                            state_reg <= ST_MAKE;
                            s_reg     <= oh_full[N_IN-1:0];
                        end
                    end
                end
                ST_MAKE: begin
                    if (dwell_zero) begin
                        state_reg <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    state_reg      <= ST_RESP;
                    rsp_valid_reg  <= 1'b1;
                    rsp_data_reg   <= ~ZN_0;
                    rsp_err_reg    <= 1'b0;
                    active_reg     <= 1'b1;
                    active_sel_reg <= sel_reg;
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        state_reg     <= ST_IDLE;
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    s_reg     <= '0;
                end
            endcase
        end
    end

    assign REQ_READY = req_ready_reg;
    assign RSP_VALID = rsp_valid_reg;
    assign RSP_DATA  = rsp_data_reg;
    assign RSP_ERR   = rsp_err_reg;
    assign S         = s_reg;

endmodule

// File: tb/tb_nem_ohmux_seldrv.sv
// Bench for nem_ohmux_seldrv: a 4-input and a 3-input instance driven with directed
// and random select requests, checked against a per-transaction schedule model.
module tb_nem_ohmux_seldrv;

    localparam int OFF = 2;
    localparam int ON  = 4;

    logic       clk;
    logic       rstn;

    logic       valid4, ready4, rvalid4, rready4, rdata4, rerr4, zn4;
    logic [1:0] sel4;
    logic [3:0] s4;

    logic       valid3, ready3, rvalid3, rready3, rdata3, rerr3, zn3;
    logic [1:0] sel3;
    logic [2:0] s3;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: which relay each column believes is closed.
    bit act4 = 1'b0, act3 = 1'b0;
    int asel4 = 0, asel3 = 0;

    nem_ohmux_seldrv #(.N_IN(4), .OFF_CYC(OFF), .ON_CYC(ON), .CNTW(8)) dut4 (
        .CP(clk), .RSTN(rstn),
        .REQ_VALID(valid4), .REQ_READY(ready4), .REQ_SEL(sel4),
        .RSP_VALID(rvalid4), .RSP_READY(rready4), .RSP_DATA(rdata4), .RSP_ERR(rerr4),
        .S(s4), .ZN_0(zn4)
    );

    nem_ohmux_seldrv #(.N_IN(3), .OFF_CYC(OFF), .ON_CYC(ON), .CNTW(8)) dut3 (
        .CP(clk), .RSTN(rstn),
        .REQ_VALID(valid3), .REQ_READY(ready3), .REQ_SEL(sel3),
        .RSP_VALID(rvalid3), .RSP_READY(rready3), .RSP_DATA(rdata3), .RSP_ERR(rerr3),
        .S(s3), .ZN_0(zn3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] obs_s(input bit d3);
        return d3 ? {1'b0, s3} : s4;
    endfunction
    function automatic logic obs_ready(input bit d3);
        return d3 ? ready3 : ready4;
    endfunction
    function automatic logic obs_valid(input bit d3);
        return d3 ? rvalid3 : rvalid4;
    endfunction
    function automatic logic obs_data(input bit d3);
        return d3 ? rdata3 : rdata4;
    endfunction
    function automatic logic obs_err(input bit d3);
        return d3 ? rerr3 : rerr4;
    endfunction

    // One request/response transaction; inputs change only at negedges or #1 after posedge.
    task automatic txn(input bit d3, input int sel, input bit zn, input int bp);
        bit       act, err, fastp;
        int       asel, lat, guard, n;
        logic [3:0] es;
        logic     hold_d;
        n     = d3 ? 3 : 4;
        act   = d3 ? act3 : act4;
        asel  = d3 ? asel3 : asel4;
        err   = (sel >= n);
        fastp = !err && act && (asel == sel);
        lat   = fastp ? 2 : (err ? OFF + 1 : OFF + ON + 2);
        guard = 0;
        while (!obs_ready(d3) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_wait", 32'(obs_ready(d3)), 32'd1);
        if (d3) begin valid3 = 1'b1; sel3 = 2'(sel); zn3 = zn; end
        else    begin valid4 = 1'b1; sel4 = 2'(sel); zn4 = zn; end
        @(posedge clk);
        #1;
        if (d3) begin valid3 = 1'b0; sel3 = 2'($urandom); end
        else    begin valid4 = 1'b0; sel4 = 2'($urandom); end
        es = 4'h0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            es = (fastp || (!err && k > OFF)) ? 4'(1 << sel) : 4'h0;
            check($sformatf("s_seq k=%0d sel=%0d", k, sel), 32'(obs_s(d3)), 32'(es));
            check($sformatf("rsp_valid k=%0d", k), 32'(obs_valid(d3)), 32'(k == lat));
            check("req_ready_busy", 32'(obs_ready(d3)), 32'd0);
        end
        hold_d = err ? 1'b0 : ~zn;
        check("rsp_data", 32'(obs_data(d3)), 32'(hold_d));
        check("rsp_err", 32'(obs_err(d3)), 32'(err));
        for (int b = 0; b < bp; b++) begin
            if (d3) zn3 = ~zn3; else zn4 = ~zn4;
            @(negedge clk);
            check("bp_valid", 32'(obs_valid(d3)), 32'd1);
            check("bp_data", 32'(obs_data(d3)), 32'(hold_d));
            check("bp_err", 32'(obs_err(d3)), 32'(err));
            check("bp_s", 32'(obs_s(d3)), 32'(es));
            check("bp_ready", 32'(obs_ready(d3)), 32'd0);
        end
        if (d3) rready3 = 1'b1; else rready4 = 1'b1;
        @(negedge clk);
        if (d3) rready3 = 1'b0; else rready4 = 1'b0;
        check("post_valid", 32'(obs_valid(d3)), 32'd0);
        check("post_ready", 32'(obs_ready(d3)), 32'd1);
        check("post_s_held", 32'(obs_s(d3)), 32'(es));
        if (d3) begin act3 = !err; asel3 = sel; end
        else    begin act4 = !err; asel4 = sel; end
        $display("txn dut%0d sel=%0d zn=%0d bp=%0d path=%s", n, sel, zn, bp,
                 fastp ? "fast" : (err ? "err" : "full"));
    endtask

    initial begin
        int guard;
        rstn = 1'b0;
        valid4 = 1'b0; sel4 = '0; rready4 = 1'b0; zn4 = 1'b0;
        valid3 = 1'b0; sel3 = '0; rready3 = 1'b0; zn3 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s4", 32'(s4), 32'd0);
        check("rst_valid4", 32'(rvalid4), 32'd0);
        check("rst_data4", 32'(rdata4), 32'd0);
        check("rst_err4", 32'(rerr4), 32'd0);
        check("rst_s3", 32'(s3), 32'd0);
        check("rst_valid3", 32'(rvalid3), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("rel_ready4", 32'(ready4), 32'd1);
        check("rel_ready3", 32'(ready3), 32'd1);

        // Directed: normal, switch, fast, backpressure, error then full path.
        txn(1'b0, 2, 1'b0, 0);
        txn(1'b0, 1, 1'b0, 0);
        txn(1'b0, 1, 1'b1, 0);
        txn(1'b0, 1, 1'b0, 5);
        txn(1'b1, 3, 1'b0, 2);
        txn(1'b1, 0, 1'b1, 0);
        txn(1'b1, 0, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
            bit d3;
            int sel;
            d3  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) sel = d3 ? asel3 : asel4;
            txn(d3, sel, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Reset in the middle of a make dwell aborts the request.
        txn(1'b0, 0, 1'b0, 0);
        guard = 0;
        while (!ready4 && guard < 50) begin @(negedge clk); guard++; end
        valid4 = 1'b1; sel4 = 2'd2;
        @(posedge clk);
        #1 valid4 = 1'b0;
        repeat (OFF + 2) @(negedge clk);
        check("mid_make_s", 32'(s4), 32'h4);
        rstn = 1'b0;
        @(negedge clk);
        check("abort_s", 32'(s4), 32'd0);
        check("abort_valid", 32'(rvalid4), 32'd0);
        rstn = 1'b1;
        act4 = 1'b0; act3 = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready4), 32'd1);
        repeat (ON + 2) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rvalid4), 32'd0);
        end
        txn(1'b0, 2, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
